// File: rtl/systolic_output_collector_pkg.sv
// Shared types and helpers for the systolic output collector.
//   row_t         one de-skewed result row at default geometry, col c in element [c]
//   coll_state_e  collector FSM encoding (IDLE / COLLECT / DRAIN)
//   fifo_cnt_w    occupancy counter width for a row FIFO of a given depth
package systolic_output_collector_pkg;

  localparam int P_WIDTH      = 8;
  localparam int P_COLS       = 4;
  localparam int P_ROWS       = 4;
  localparam int P_FIFO_DEPTH = 4;

  typedef logic signed [P_COLS-1:0][P_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } coll_state_e;

  // Needs to hold the value DEPTH itself, hence one bit more than the pointer.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/systolic_output_collector_if.sv
// Data-path bundle between the array, the collector and the downstream consumer.
//   south      skewed column data from the array, col c at [c*WIDTH +: WIDTH]
//   col_valid  per-column sample valid, skewed like south
//   row        de-skewed row at the FIFO head, same packing as south
//   row_valid  row holds a valid row
//   row_ready  downstream can take the row
//   row_last   row is the final row of its tile
// Handshake: a row transfers on every rising clk edge where row_valid && row_ready.
// While row_valid is high and row_ready is low, row and row_last hold stable.
// row_valid never waits on row_ready.
interface systolic_output_collector_if #(
  parameter int WIDTH = 8,
  parameter int COLS  = 4
);
  logic [COLS*WIDTH-1:0] south;
  logic [COLS-1:0]       col_valid;
  logic [COLS*WIDTH-1:0] row;
  logic                  row_valid;
  logic                  row_ready;
  logic                  row_last;

  // Collector side: consumes the array stream, sources the row stream.
  modport master (
    input  south, col_valid, row_ready,
    output row, row_valid, row_last
  );

  // Environment side: drives the array stream, consumes rows.
  modport slave (
    output south, col_valid, row_ready,
    input  row, row_valid, row_last
  );
endinterface

// File: rtl/systolic_output_collector_row_fifo.sv
// Synchronous row FIFO for the collector.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        synchronous flush, wins over push/pop
//   push_i/data_i  write request and entry ({last tag, row})
//   pop_i          read request; ignored when empty
//   data_o         head entry, zero when empty
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries
// A push while full is accepted only when a pop happens on the same edge.
module systolic_output_collector_row_fifo
  import systolic_output_collector_pkg::*;
#(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          push_i,
  input  logic [DW-1:0]                 data_i,
  input  logic                          pop_i,
  output logic [DW-1:0]                 data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = cnt;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem[wr_ptr] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/systolic_output_collector.sv
// De-skews the bottom-row result streams of the systolic array, assembles one
// row per cycle, buffers rows and presents them on a valid/ready stream.
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   clear_i      synchronous flush of FIFO, counters, flags, deskew; state -> IDLE
//   bus          array stream in, row stream out (see the interface)
//   tile_done_o  one-cycle pulse the cycle after the last row of a tile is popped
//   overflow_o   sticky: an aligned row was dropped because the FIFO was full
//   skew_err_o   sticky: aligned column valids disagreed
//   state_o      current FSM state (coll_state_e encoding)
//   fill_o       current FIFO occupancy
module systolic_output_collector
  import systolic_output_collector_pkg::*;
#(
  parameter int WIDTH      = P_WIDTH,
  parameter int COLS       = P_COLS,
  parameter int ROWS       = P_ROWS,
  parameter int FIFO_DEPTH = P_FIFO_DEPTH
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  systolic_output_collector_if.master        bus,
  output logic                               tile_done_o,
  output logic                               overflow_o,
  output logic                               skew_err_o,
  output logic [1:0]                         state_o,
  output logic [fifo_cnt_w(FIFO_DEPTH)-1:0]  fill_o
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_DRAIN   = DRAIN;
  localparam int         RW         = COLS * WIDTH;
  localparam int         RCW        = $clog2(ROWS + 1);

  // ---------------- deskew ----------------
  // Column c is sampled c cycles after column 0, so it is delayed by
  // COLS-1-c registers; all columns of one row then line up together.
  logic [WIDTH-1:0] al_data [COLS];
  logic [COLS-1:0]  al_vld;
  logic [RW-1:0]    al_row;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign al_data[c] = bus.south[c*WIDTH +: WIDTH];
      assign al_vld[c]  = bus.col_valid[c];
    end else begin : g_delay
      logic [WIDTH-1:0] dq [D];
      logic [D-1:0]     vq;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vq <= '0;
          for (int i = 0; i < D; i++) dq[i] <= '0;
        end else if (clear_i) begin
          vq <= '0;
          for (int i = 0; i < D; i++) dq[i] <= '0;
        end else begin
          dq[0] <= bus.south[c*WIDTH +: WIDTH];
          vq[0] <= bus.col_valid[c];
          for (int i = 1; i < D; i++) begin
            dq[i] <= dq[i-1];
            vq[i] <= vq[i-1];
          end
        end
      end
      assign al_data[c] = dq[D-1];
      assign al_vld[c]  = vq[D-1];
    end
  end

  always_comb begin
    al_row = '0;
    for (int c = 0; c < COLS; c++) al_row[c*WIDTH +: WIDTH] = al_data[c];
  end

  logic row_ok;
  logic row_bad;
  assign row_ok  = &al_vld;
  assign row_bad = (|al_vld) && !row_ok;

  // ---------------- row FIFO ----------------
  logic [RCW-1:0] row_cnt;
  logic [1:0]     state;
  logic           last_tag;
  logic           fifo_full;
  logic           fifo_empty;
  logic [RW:0]    head;
  logic           pop;

  assign last_tag = (row_cnt == RCW'(ROWS - 1));
  assign pop      = !fifo_empty && bus.row_ready;

  systolic_output_collector_row_fifo #(
    .DW    (RW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (row_ok),
    .data_i  ({last_tag, al_row}),
    .pop_i   (bus.row_ready),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill_o)
  );

  assign bus.row       = head[RW-1:0];
  assign bus.row_last  = head[RW];
  assign bus.row_valid = !fifo_empty;

  // ---------------- tile tracking ----------------
  // Dropped rows still advance row_cnt so tile boundaries stay aligned with
  // the array's output even after an overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      row_cnt     <= '0;
      tile_done_o <= 1'b0;
      overflow_o  <= 1'b0;
      skew_err_o  <= 1'b0;
    end else if (clear_i) begin
      state       <= ST_IDLE;
      row_cnt     <= '0;
      tile_done_o <= 1'b0;
      overflow_o  <= 1'b0;
      skew_err_o  <= 1'b0;
    end else begin
      tile_done_o <= pop && bus.row_last;
      if (row_ok && fifo_full && !pop) overflow_o <= 1'b1;
      if (row_bad) skew_err_o <= 1'b1;
      if (row_ok) row_cnt <= last_tag ? '0 : row_cnt + 1'b1;
      case (state)
        ST_IDLE:    if (row_ok) state <= last_tag ? ST_DRAIN : ST_COLLECT;
        ST_COLLECT: if (row_ok && last_tag) state <= ST_DRAIN;
        ST_DRAIN:   if (pop && bus.row_last) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_systolic_output_collector.sv
`timescale 1ns/1ps
module tb_systolic_output_collector;
  import systolic_output_collector_pkg::*;

  localparam int W  = P_WIDTH;
  localparam int C  = P_COLS;
  localparam int R  = P_ROWS;
  localparam int D  = P_FIFO_DEPTH;
  localparam int EW = C*W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic                        tile_done;
  logic                        overflow;
  logic                        skew_err;
  logic [1:0]                  state;
  logic [fifo_cnt_w(D)-1:0]    fill;

  systolic_output_collector_if #(.WIDTH(W), .COLS(C)) bus ();

  systolic_output_collector #(
    .WIDTH(W), .COLS(C), .ROWS(R), .FIFO_DEPTH(D)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .bus         (bus),
    .tile_done_o (tile_done),
    .overflow_o  (overflow),
    .skew_err_o  (skew_err),
    .state_o     (state),
    .fill_o      (fill)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            td_cnt = 0;

  always @(negedge clk) begin
    if (!rst && bus.row_valid && bus.row_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row: got %0h expected none", bus.row);
      end else begin
        mon_e = exp_q.pop_front();
        check("row_data", 64'(bus.row), 64'(mon_e[C*W-1:0]));
        check("row_last", 64'(bus.row_last), 64'(mon_e[EW-1]));
      end
    end
    if (!rst && tile_done) td_cnt++;
  end

  // ---------------- drivers ----------------
  row_t         src [16];
  logic [C-1:0] vm  [16];
  logic         acc [16];
  int           mdl_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n rows with the array skew. Expected entries (with the tile last tag
  // from the bench's own row counter) are queued for rows marked acceptable.
  // rdy_k >= 0 raises row_ready only during drive cycle rdy_k.
  task automatic drive_rows(input int n, input int rdy_k);
    int r;
    for (int i = 0; i < n; i++) begin
      if (vm[i] == '1) begin
        if (acc[i]) exp_q.push_back({(mdl_cnt == R-1), src[i]});
        mdl_cnt = (mdl_cnt == R-1) ? 0 : mdl_cnt + 1;
      end
    end
    for (int k = 0; k < n + C - 1; k++) begin
      for (int c = 0; c < C; c++) begin
        r = k - c;
        if (r >= 0 && r < n) begin
          bus.south[c*W +: W] = src[r][c];
          bus.col_valid[c]    = vm[r][c];
        end else begin
          bus.south[c*W +: W] = '0;
          bus.col_valid[c]    = 1'b0;
        end
      end
      if (rdy_k >= 0) bus.row_ready = (k == rdy_k);
      step();
    end
    bus.south     = '0;
    bus.col_valid = '0;
    if (rdy_k >= 0) bus.row_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    mdl_cnt = 0;
  endtask

  task automatic drain(input string name);
    int i;
    bus.row_ready = 1'b1;
    for (i = 0; i < 60 && (exp_q.size() != 0 || bus.row_valid); i++) step();
    check(name, 64'(exp_q.size() == 0 && !bus.row_valid), 64'd1);
  endtask

  task automatic rand_rows(input int n, input int n_acc);
    for (int i = 0; i < n; i++) begin
      src[i] = row_t'($urandom_range(32'hFFFF_FFFF, 0));
      vm[i]  = '1;
      acc[i] = (i < n_acc);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    row_t         data;
    logic [C-1:0] vmask;
    logic         exp_valid;
    logic         exp_skew;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{data: {8'hFC, 8'h03, 8'h02, 8'h01}, vmask: 4'b1111, exp_valid: 1'b1, exp_skew: 1'b0};
    tbl[1] = '{data: {8'h80, 8'h7F, 8'h00, 8'hFF}, vmask: 4'b1111, exp_valid: 1'b1, exp_skew: 1'b0};
    tbl[2] = '{data: {8'h05, 8'h06, 8'h07, 8'h08}, vmask: 4'b1011, exp_valid: 1'b0, exp_skew: 1'b1};
    tbl[3] = '{data: {8'h09, 8'h09, 8'h09, 8'h09}, vmask: 4'b0000, exp_valid: 1'b0, exp_skew: 1'b0};

    bus.south     = '0;
    bus.col_valid = '0;
    bus.row_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();

    // reset state
    check("rst_row_valid", 64'(bus.row_valid), 64'd0);
    check("rst_row",       64'(bus.row),       64'd0);
    check("rst_row_last",  64'(bus.row_last),  64'd0);
    check("rst_tile_done", 64'(tile_done),     64'd0);
    check("rst_overflow",  64'(overflow),      64'd0);
    check("rst_skew_err",  64'(skew_err),      64'd0);
    check("rst_state",     64'(state),         64'(IDLE));
    check("rst_fill",      64'(fill),          64'd0);

    // single rows: valid right after the col3 sample edge, popped one edge later
    for (int i = 0; i < 4; i++) begin
      do_clear();
      bus.row_ready = 1'b1;
      src[0] = tbl[i].data;
      vm[0]  = tbl[i].vmask;
      acc[0] = 1'b1;
      drive_rows(1, -1);
      check("tbl_valid",    64'(bus.row_valid), 64'(tbl[i].exp_valid));
      check("tbl_skew",     64'(skew_err),      64'(tbl[i].exp_skew));
      check("tbl_overflow", 64'(overflow),      64'd0);
      step();
      check("tbl_popped",   64'(bus.row_valid), 64'd0);
    end

    // full tile, ready held high
    do_clear();
    td_cnt = 0;
    bus.row_ready = 1'b1;
    rand_rows(4, 4);
    drive_rows(4, -1);
    drain("tile_drain");
    repeat (2) step();
    check("tile_done_pulses", 64'(td_cnt), 64'd1);
    check("tile_state_idle",  64'(state),  64'(IDLE));

    // backpressure: 6 rows into a 4-deep FIFO
    do_clear();
    td_cnt = 0;
    bus.row_ready = 1'b0;
    rand_rows(6, 4);
    drive_rows(6, -1);
    step();
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_fill",     64'(fill),     64'd4);
    check("bp_state",    64'(state),    64'(DRAIN));
    drain("bp_drain");
    repeat (2) step();
    check("bp_tile_done",  64'(td_cnt), 64'd1);
    check("bp_state_idle", 64'(state),  64'(IDLE));

    // skew fault is sticky until clear
    do_clear();
    bus.row_ready = 1'b1;
    rand_rows(2, 2);
    vm[0] = 4'b1011;
    drive_rows(2, -1);
    drain("skew_drain");
    check("skew_sticky", 64'(skew_err), 64'd1);
    do_clear();
    check("skew_cleared", 64'(skew_err), 64'd0);

    // full FIFO with a pop on the same edge as the write
    do_clear();
    td_cnt = 0;
    bus.row_ready = 1'b0;
    rand_rows(4, 4);
    drive_rows(4, -1);
    check("full_fill", 64'(fill), 64'd4);
    rand_rows(1, 1);
    drive_rows(1, 3);
    check("fullpop_fill",     64'(fill),     64'd4);
    check("fullpop_overflow", 64'(overflow), 64'd0);
    drain("fullpop_drain");
    repeat (2) step();
    check("fullpop_tile_done", 64'(td_cnt), 64'd1);

    // asynchronous reset mid-tile
    do_clear();
    bus.row_ready = 1'b0;
    rand_rows(2, 2);
    drive_rows(2, -1);
    check("pre_rst_valid", 64'(bus.row_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 64'(bus.row_valid), 64'd0);
    check("rst_async_fill",  64'(fill),          64'd0);
    check("rst_async_state", 64'(state),         64'(IDLE));
    exp_q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    td_cnt = 0;
    bus.row_ready = 1'b1;
    rand_rows(4, 4);
    drive_rows(4, -1);
    drain("post_rst_drain");
    repeat (2) step();
    check("post_rst_tile_done", 64'(td_cnt), 64'd1);
    check("post_rst_state",     64'(state),  64'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
